// File: rtl/easyaxi_rd_slv.sv
// AXI4 read-channel responder: accepts one AR burst at a time and answers it with
// address-derived beat data, flagging illegal bursts and out-of-window beats with SLVERR.
module easyaxi_rd_slv #(
    parameter int                    ID_WIDTH   = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h0000_0000,
    parameter int unsigned           MEM_SIZE   = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   axi_slv_arid,
    input  logic [ADDR_WIDTH-1:0] axi_slv_araddr,
    input  logic [7:0]            axi_slv_arlen,
    input  logic [2:0]            axi_slv_arsize,
    input  logic [1:0]            axi_slv_arburst,
    input  logic                  axi_slv_arvalid,
    output logic                  axi_slv_arready,
    output logic [ID_WIDTH-1:0]   axi_slv_rid,
    output logic [DATA_WIDTH-1:0] axi_slv_rdata,
    output logic [1:0]            axi_slv_rresp,
    output logic                  axi_slv_rlast,
    output logic                  axi_slv_rvalid,
    input  logic                  axi_slv_rready
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH/8);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q, cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  berr_q;

    logic                  ar_hs, r_hs, ar_err;
    logic [ADDR_WIDTH-1:0] bytes, total, wrap_lower, seq_addr, nxt_addr;
    logic [ADDR_WIDTH-1:0] beat_addr, beat_off;
    logic                  beat_err;

    assign ar_hs = axi_slv_arvalid & axi_slv_arready;
    assign r_hs  = axi_slv_rvalid & axi_slv_rready;

    assign ar_err = (axi_slv_arburst == 2'b11) ||
                    (axi_slv_arburst == 2'b10 &&
                     !(axi_slv_arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                    (axi_slv_arsize > 3'(MAX_SIZE));

    // Address of the following beat; the WRAP mask relies on total being a
    // power of two, which holds for every burst that is not already SLVERR.
    always_comb begin
        bytes      = ADDR_WIDTH'(1) << size_q;
        total      = bytes * (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1));
        wrap_lower = addr_q & ~(total - ADDR_WIDTH'(1));
        seq_addr   = addr_q + bytes;
        case (burst_q)
            2'b01:   nxt_addr = (addr_q & ~(bytes - ADDR_WIDTH'(1))) + bytes;
            2'b10:   nxt_addr = (seq_addr == wrap_lower + total) ? wrap_lower : seq_addr;
            default: nxt_addr = addr_q;
        endcase
    end

    // In IDLE the beat being prepared is beat 0 of the incoming request.
    always_comb begin
        beat_addr = (state_q == IDLE) ? axi_slv_araddr : nxt_addr;
        beat_off  = beat_addr - MEM_BASE;
        beat_err  = ((state_q == IDLE) ? ar_err : berr_q) ||
                    (beat_addr < MEM_BASE) || (beat_off >= ADDR_WIDTH'(MEM_SIZE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_hs) state_d = BURST;
            BURST:   if (r_hs && axi_slv_rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axi_slv_arready <= 1'b0;
            axi_slv_rvalid  <= 1'b0;
            axi_slv_rlast   <= 1'b0;
            axi_slv_rresp   <= 2'b00;
            axi_slv_rid     <= '0;
            axi_slv_rdata   <= '0;
            addr_q          <= '0;
            len_q           <= '0;
            cnt_q           <= '0;
            size_q          <= '0;
            burst_q         <= '0;
            berr_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_hs) begin
                        addr_q          <= axi_slv_araddr;
                        len_q           <= axi_slv_arlen;
                        size_q          <= axi_slv_arsize;
                        burst_q         <= axi_slv_arburst;
                        berr_q          <= ar_err;
                        cnt_q           <= '0;
                        axi_slv_arready <= 1'b0;
                        axi_slv_rvalid  <= 1'b1;
                        axi_slv_rid     <= axi_slv_arid;
                        axi_slv_rlast   <= (axi_slv_arlen == 8'd0);
                        axi_slv_rresp   <= beat_err ? 2'b10 : 2'b00;
                        axi_slv_rdata   <= beat_err ? '0 : DATA_WIDTH'(beat_addr);
                    end else begin
                        axi_slv_arready <= 1'b1;
                    end
                end
                BURST: begin
                    if (r_hs) begin
                        if (axi_slv_rlast) begin
                            axi_slv_rvalid  <= 1'b0;
                            axi_slv_rlast   <= 1'b0;
                            axi_slv_arready <= 1'b1;
                        end else begin
                            cnt_q         <= cnt_q + 8'd1;
                            addr_q        <= nxt_addr;
                            axi_slv_rlast <= (cnt_q + 8'd1 == len_q);
                            axi_slv_rresp <= beat_err ? 2'b10 : 2'b00;
                            axi_slv_rdata <= beat_err ? '0 : DATA_WIDTH'(beat_addr);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
